button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Front-end input stage between the raw board push-buttons and the ship position FSM and fire logic.
- Synchronises, debounces and edge-detects the left, right and fire buttons.
- Emits single-cycle pulses on left_debounced, right_debounced and fire_debounced, so the ship moves exactly one position per press.

Parameters:
- DEBOUNCE_CYCLES, 360000, consecutive cycles a synchronised input must differ from its stable state before the stable state flips (10 ms at 36 MHz); must be ≥2.
- REPEAT_DELAY, 18000000, cycles from press pulse to first auto-repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 3600000, cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only).
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk_36MHz  input  1  system clock
- reset  input  1  synchronous, active-high reset
- left_raw  input  1  asynchronous button, 1 = pressed
- right_raw  input  1  asynchronous button, 1 = pressed
- fire_raw  input  1  asynchronous button, 1 = pressed
- enable  input  1  1 = pulses allowed out
- left_debounced  output  1  one-cycle move-left pulse
- right_debounced  output  1  one-cycle move-right pulse
- fire_debounced  output  1  one-cycle fire pulse

Behaviour:
- Clock and reset: one clock, clk_36MHz. reset is synchronous and active-high. All registers update on the rising edge only.
- Reset values: all outputs, synchronisers, stable states and counters are 0.
- Per-channel structure (left, right, fire identical): 2-FF synchroniser (sync1, sync2), a stable register, and a CNT_W-bit debounce counter.
- Debounce counter:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - Otherwise: counter <= counter + 1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is fully rejected and resets the count.
- Press detection: a stable 0->1 transition raises that channel's press event. The press event is registered in the same edge that flips stable.
- Latency: with raw first sampled high at edge 0 and held, the pulse is high in the cycle after edge DEBOUNCE_CYCLES+1. The pulse is exactly 1 cycle wide.
- Release (stable 1->0) produces no pulse.
- Pulse gating:
  - Each output pulse = press event AND enable.
  - While enable = 0, debouncing and stable tracking continue.
  - A button already held when enable rises produces no pulse until it is released and pressed again.
- Left/right conflict: if left and right press events coincide in one cycle, both left_debounced and right_debounced are 0 that cycle. fire is unaffected. The left/right outputs are therefore never high together.
- Reset mid-operation: outputs are 0 in the cycle after the reset edge; counters and stable states are cleared. A button still held after reset deasserts is re-debounced from scratch and produces one new pulse.
- Counters never wrap: they saturate by the rules above.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - left and right each get a CNT_W-bit repeat counter, cleared on press event, on stable = 0, and on reset.
  - While stable = 1, the counter increments each cycle.
  - On reaching REPEAT_DELAY-1, a repeat pulse is emitted and the counter is loaded so that further pulses occur every REPEAT_PERIOD cycles while held.
  - Repeat pulses pass through the same enable gating and left/right conflict rule.
  - fire never repeats.
- Undefined: repeat logic absent; exactly one pulse per debounced press.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: left_raw 0->1 at edge 0, held 20 cycles, enable=1 -> left_debounced high only in the cycle after edge 5; right/fire stay 0; no pulse on release.
- Glitch rejection: right_raw high for 3 cycles then low, repeated 5 times -> right_debounced never asserts; then held 6 cycles -> exactly one pulse.
- Conflict and enable: left_raw and right_raw rise on the same edge -> no left/right pulse, while fire pressed in the same cycle still pulses. Separately, hold fire with enable=0, raise enable at edge 10 -> no pulse until release and re-press.
- Reset mid-debounce: left_raw held; assert reset at edge 3 for 1 cycle -> no pulse at edge 5; pulse appears DEBOUNCE_CYCLES+2 edges after reset deasserts.
- Auto-repeat (BUTTON_AUTO_REPEAT_EN defined): hold right_raw 30 cycles -> pulses after edges 5, 15, 18, 21, 24, 27, 30 (repeats stop within 2+DEBOUNCE_CYCLES cycles of release). With the macro undefined -> a single pulse after edge 5.

Source files
------------

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect the left/right/fire buttons into single-cycle pulses.
// Define BUTTON_AUTO_REPEAT_EN to add held-button auto-repeat on left and right.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 360000,
  parameter int unsigned REPEAT_DELAY    = 18000000,
  parameter int unsigned REPEAT_PERIOD   = 3600000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk_36MHz,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  input  logic fire_raw,
  input  logic enable,
  output logic left_debounced,
  output logic right_debounced,
  output logic fire_debounced
);

  localparam int unsigned NumCh = 3;
  localparam logic [CNT_W-1:0] CntOne = 1;
  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel index: 0 = left, 1 = right, 2 = fire.
  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] sync1_d, sync1_q;
  logic [NumCh-1:0] sync2_d, sync2_q;
  logic [NumCh-1:0] stable_d, stable_q;
  logic [NumCh-1:0] press_d;
  logic [CNT_W-1:0] db_cnt_d [NumCh];
  logic [CNT_W-1:0] db_cnt_q [NumCh];
  logic [1:0]       move_evt;
  logic             left_d, left_q;
  logic             right_d, right_q;
  logic             fire_d, fire_q;

  assign raw     = {fire_raw, right_raw, left_raw};
  assign sync1_d = raw;
  assign sync2_d = sync1_q;

  // Any sample that agrees with the stable state restarts the count, so only an unbroken run
  // of DEBOUNCE_CYCLES disagreeing samples flips the stable state.
  always_comb begin
    for (int ch = 0; ch < NumCh; ch++) begin
      stable_d[ch] = stable_q[ch];
      db_cnt_d[ch] = '0;
      press_d[ch]  = 1'b0;
      if (sync2_q[ch] != stable_q[ch]) begin
        if (db_cnt_q[ch] == DbLast) begin
          stable_d[ch] = sync2_q[ch];
          press_d[ch]  = sync2_q[ch];
        end else begin
          db_cnt_d[ch] = db_cnt_q[ch] + CntOne;
        end
      end
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RptLast   = CNT_W'(REPEAT_DELAY - 1);
  // Reloading PERIOD short of the terminal count spaces later pulses PERIOD cycles apart.
  localparam logic [CNT_W-1:0] RptReload = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CNT_W-1:0] rpt_cnt_d [2];
  logic [CNT_W-1:0] rpt_cnt_q [2];
  logic [1:0]       rpt_evt;

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      rpt_evt[ch]   = stable_q[ch] && (rpt_cnt_q[ch] == RptLast);
      rpt_cnt_d[ch] = rpt_cnt_q[ch] + CntOne;
      if (!stable_q[ch] || press_d[ch]) begin
        rpt_cnt_d[ch] = '0;
      end else if (rpt_evt[ch]) begin
        rpt_cnt_d[ch] = RptReload;
      end
    end
  end

  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      rpt_cnt_q <= '{default: '0};
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign move_evt = press_d[1:0] | rpt_evt;
`else
  logic [2*CNT_W-1:0] unused_rpt_cfg;
  assign unused_rpt_cfg = {CNT_W'(REPEAT_DELAY), CNT_W'(REPEAT_PERIOD)};
  assign move_evt       = press_d[1:0];
`endif

  // Simultaneous left and right cancel each other; fire is independent.
  always_comb begin
    left_d  = enable & move_evt[0] & ~move_evt[1];
    right_d = enable & move_evt[1] & ~move_evt[0];
    fire_d  = enable & press_d[2];
  end

  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      db_cnt_q <= '{default: '0};
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      fire_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      left_q   <= left_d;
      right_q  <= right_d;
      fire_q   <= fire_d;
    end
  end

  assign left_debounced  = left_q;
  assign right_debounced = right_q;
  assign fire_debounced  = fire_q;

endmodule
